hifp_result_packer: RTL and testbench

- Downstream consumer of the hifp kernel function's 16-bit result stream (valid/ready).
- Packs 32 consecutive 16-bit results into one 512-bit line and issues single-beat Avalon-MM writes to the local memory interconnect at consecutive 64-byte-aligned addresses.
- Tracks outstanding writeacks.
- Supports an end-of-work flush that writes a partial line with a sparse byteenable and reports completion once all writes are acknowledged.

---
 rtl/hifp_pack_pkg.sv | 23 ++
 rtl/hifp_ack_counter.sv | 45 ++++
 rtl/hifp_result_packer.sv | 178 +++++++++++++++++
 tb/tb_hifp_result_packer.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hifp_pack_pkg.sv
// Shared definitions for the hifp result packer: line geometry, the
// packer state encoding and the byteenable helper.
package hifp_pack_pkg;

   localparam int LANES      = 32;
   localparam int LANE_W     = 16;
   localparam int LINE_BYTES = 64;
   localparam int LINE_W     = LANES * LANE_W;
   localparam int BE_W       = LANES * 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      WRITE = 2'd2,
      DRAIN = 2'd3
   } state_e;

   // Two byteenable bits cover one 16-bit lane.
   function automatic logic [BE_W-1:0] be_pair(input logic [4:0] lane);
      be_pair = {{(BE_W-2){1'b0}}, 2'b11} << {lane, 1'b0};
   endfunction

endpackage

// File: rtl/hifp_ack_counter.sv
// Outstanding-write counter for the hifp result packer. Counts up on every
// accepted write and down on every writeack, and flags full/empty.
module hifp_ack_counter #(
   parameter int MAX_PENDING = 8
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic inc_i,
   input  logic dec_i,
   output logic full_o,
   output logic zero_o
);

   localparam int CNT_W = $clog2(MAX_PENDING + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dec_eff;

   // An ack with nothing outstanding is a protocol error and is dropped.
   assign dec_eff = dec_i && !zero_o;
   assign zero_o  = (cnt_q == '0);
   assign full_o  = (cnt_q == CNT_W'(MAX_PENDING));

   // Next count: simultaneous write and ack cancel out.
   always_comb begin
      cnt_d = cnt_q;
      unique case ({inc_i, dec_eff})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Count register.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end

   // Catch acknowledgements that arrive with nothing outstanding.
   always @(posedge clk_i) begin
      if (rst_n_i) assert (!(dec_i && zero_o));
   end

endmodule

// File: rtl/hifp_result_packer.sv
// Packs 32 consecutive 16-bit hifp results into one 512-bit line and writes
// each line as a single-beat Avalon-MM write to consecutive 64-byte lines.
// A flush writes the partial line (sparse byteenable) and reports completion
// once every write has been acknowledged.
// Optional build macro HIFP_PACK_STATS_EN adds the write-stall counter on
// stat_stall_cycles; without it that port is tied to zero.
module hifp_result_packer
   import hifp_pack_pkg::*;
#(
   parameter int MAX_PENDING = 8,
   parameter int ADDR_W      = 32
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              m_start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              m_valid_in,
   input  logic [15:0]       m_input_data,
   output logic              m_ready_out,
   input  logic              flush,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_write,
   output logic [511:0]      avm_writedata,
   output logic [63:0]       avm_byteenable,
   output logic [4:0]        avm_burstcount,
   output logic              avm_read,
   input  logic              avm_waitrequest,
   input  logic              avm_writeack,
   output logic              has_a_write_pending,
   output logic              flush_done,
   output logic [31:0]       lines_written,
   output logic [31:0]       stat_stall_cycles
);

   state_e            state_q, state_d;
   logic [5:0]        lane_idx_q, lane_idx_d;
   logic [LINE_W-1:0] buf_q, buf_d;
   logic [BE_W-1:0]   be_q, be_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [ADDR_W-1:0] line_idx_q, line_idx_d;
   logic [31:0]       lines_q, lines_d;
   logic              flush_lat_q, flush_lat_d;

   logic accept;
   logic wr_fire;
   logic pend_full;
   logic pend_zero;

   assign m_ready_out         = (state_q == FILL);
   assign accept              = m_valid_in && m_ready_out;
   // Hold the line back while too many writes are unacknowledged.
   assign avm_write           = (state_q == WRITE) && !pend_full;
   assign wr_fire             = avm_write && !avm_waitrequest;
   assign avm_address         = base_q + line_idx_q * ADDR_W'(LINE_BYTES);
   assign avm_writedata       = buf_q;
   assign avm_byteenable      = be_q;
   assign avm_burstcount      = 5'd1;
   assign avm_read            = 1'b0;
   assign has_a_write_pending = !pend_zero || avm_write;
   assign flush_done          = (state_q == DRAIN) && pend_zero;
   assign lines_written       = lines_q;

   hifp_ack_counter #(
      .MAX_PENDING (MAX_PENDING)
   ) u_ack_counter (
      .clk_i   (clock),
      .rst_n_i (resetn),
      .inc_i   (wr_fire),
      .dec_i   (avm_writeack),
      .full_o  (pend_full),
      .zero_o  (pend_zero)
   );

   // Next-state logic: lane fill, line write, flush and drain sequencing.
   always_comb begin
      state_d     = state_q;
      lane_idx_d  = lane_idx_q;
      buf_d       = buf_q;
      be_d        = be_q;
      base_d      = base_q;
      line_idx_d  = line_idx_q;
      lines_d     = lines_q;
      flush_lat_d = flush_lat_q;
      unique case (state_q)
         IDLE: begin
            if (m_start) begin
               base_d     = base_addr & ~ADDR_W'(LINE_BYTES - 1);
               line_idx_d = '0;
               lines_d    = '0;
               state_d    = FILL;
            end
         end
         FILL: begin
            if (accept) begin
               buf_d[{lane_idx_q[4:0], 4'b0000} +: LANE_W] = m_input_data;
               be_d       = be_q | be_pair(lane_idx_q[4:0]);
               lane_idx_d = lane_idx_q + 6'd1;
            end
            // A flush includes any result accepted in the same cycle.
            if (flush) begin
               if (lane_idx_d == '0) begin
                  state_d = DRAIN;
               end else begin
                  state_d     = WRITE;
                  flush_lat_d = 1'b1;
               end
            end else if (accept && (lane_idx_q == 6'd31)) begin
               state_d = WRITE;
            end
         end
         WRITE: begin
            if (wr_fire) begin
               line_idx_d = line_idx_q + ADDR_W'(1);
               lines_d    = lines_q + 32'd1;
               buf_d      = '0;
               be_d       = '0;
               lane_idx_d = '0;
               state_d    = flush_lat_q ? DRAIN : FILL;
            end
         end
         DRAIN: begin
            if (pend_zero) begin
               state_d     = IDLE;
               flush_lat_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and line buffer registers; reset discards any partial work.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q     <= IDLE;
         lane_idx_q  <= '0;
         buf_q       <= '0;
         be_q        <= '0;
         base_q      <= '0;
         line_idx_q  <= '0;
         lines_q     <= '0;
         flush_lat_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         lane_idx_q  <= lane_idx_d;
         buf_q       <= buf_d;
         be_q        <= be_d;
         base_q      <= base_d;
         line_idx_q  <= line_idx_d;
         lines_q     <= lines_d;
         flush_lat_q <= flush_lat_d;
      end
   end

`ifdef HIFP_PACK_STATS_EN
   logic [31:0] stall_q, stall_d;
   logic        stall_evt;

   assign stall_evt = (state_q == WRITE) && ((avm_write && avm_waitrequest) || pend_full);

   // Saturating count of slave stalls and throttled cycles; restarts per job.
   always_comb begin
      stall_d = stall_q;
      if ((state_q == IDLE) && m_start) stall_d = '0;
      else if (stall_evt && (stall_q != '1)) stall_d = stall_q + 32'd1;
   end

   // Stall counter register.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) stall_q <= '0;
      else         stall_q <= stall_d;
   end

   assign stat_stall_cycles = stall_q;
`else
   assign stat_stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_hifp_result_packer.sv
// Directed-sequence bench with randomized result data for hifp_result_packer.
// A responder process returns writeacks and logs every accepted write; the
// expected lines are built from the list of results handed to the DUT.
module tb_hifp_result_packer;

   localparam int MAXP = 2;

   logic         clock = 1'b0;
   logic         resetn = 1'b0;
   logic         m_start = 1'b0;
   logic [31:0]  base_addr = '0;
   logic         m_valid_in = 1'b0;
   logic [15:0]  m_input_data = '0;
   logic         m_ready_out;
   logic         flush = 1'b0;
   logic [31:0]  avm_address;
   logic         avm_write;
   logic [511:0] avm_writedata;
   logic [63:0]  avm_byteenable;
   logic [4:0]   avm_burstcount;
   logic         avm_read;
   logic         avm_waitrequest = 1'b0;
   logic         avm_writeack = 1'b0;
   logic         has_a_write_pending;
   logic         flush_done;
   logic [31:0]  lines_written;
   logic [31:0]  stat_stall_cycles;

   int pass_cnt = 0;
   int total_cnt = 0;

   // Responder / model state (written only by the responder process).
   int          cyc = 0;
   int          model_pending = 0;
   int          man_given = 0;
   int          due[$];
   logic [31:0] wr_addr[$];
   logic        ack_nx;

   // Responder controls (written only by the stimulus process).
   int ack_delay = 2;
   bit ack_auto = 1'b1;
   int man_release = 0;

   logic [15:0] sent[$];

   hifp_result_packer #(
      .MAX_PENDING (MAXP),
      .ADDR_W      (32)
   ) dut (
      .clock               (clock),
      .resetn              (resetn),
      .m_start             (m_start),
      .base_addr           (base_addr),
      .m_valid_in          (m_valid_in),
      .m_input_data        (m_input_data),
      .m_ready_out         (m_ready_out),
      .flush               (flush),
      .avm_address         (avm_address),
      .avm_write           (avm_write),
      .avm_writedata       (avm_writedata),
      .avm_byteenable      (avm_byteenable),
      .avm_burstcount      (avm_burstcount),
      .avm_read            (avm_read),
      .avm_waitrequest     (avm_waitrequest),
      .avm_writeack        (avm_writeack),
      .has_a_write_pending (has_a_write_pending),
      .flush_done          (flush_done),
      .lines_written       (lines_written),
      .stat_stall_cycles   (stat_stall_cycles)
   );

   always #5 clock = ~clock;

   // Slave model: logs accepted writes, tracks outstanding writes, returns acks.
   always @(posedge clock) begin
      cyc++;
      ack_nx = 1'b0;
      if (!resetn) begin
         due.delete();
         model_pending = 0;
      end else begin
         if (avm_write && !avm_waitrequest) begin
            model_pending++;
            due.push_back(cyc + ack_delay);
            wr_addr.push_back(avm_address);
         end
         if (avm_writeack && model_pending > 0) model_pending--;
         if (due.size() > 0) begin
            if (ack_auto ? (due[0] <= cyc) : (man_given < man_release)) begin
               ack_nx = 1'b1;
               void'(due.pop_front());
               if (!ack_auto) man_given++;
            end
         end
      end
      #1 avm_writeack = ack_nx;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed running, expected done");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
   endtask

   function automatic logic [511:0] exp_data();
      logic [511:0] d;
      d = '0;
      foreach (sent[i]) d[16*i +: 16] = sent[i];
      return d;
   endfunction

   function automatic logic [63:0] exp_be();
      logic [63:0] b;
      b = '0;
      foreach (sent[i]) b[2*i +: 2] = 2'b11;
      return b;
   endfunction

   task automatic start(input logic [31:0] a);
      base_addr = a;
      m_start   = 1'b1;
      @(negedge clock);
      m_start   = 1'b0;
      chk("start_fill_ready", m_ready_out, 1);
   endtask

   task automatic send(input logic [15:0] v, input logic fl);
      int n;
      m_valid_in   = 1'b1;
      m_input_data = v;
      flush        = fl;
      n = 0;
      while (m_ready_out !== 1'b1 && n < 100) begin
         @(negedge clock);
         n++;
      end
      if (n >= 100) chk("send_ready_timeout", m_ready_out, 1);
      sent.push_back(v);
      @(negedge clock);
      m_valid_in = 1'b0;
      flush      = 1'b0;
   endtask

   task automatic send_rand(input int cnt);
      for (int i = 0; i < cnt; i++) send(16'($urandom), 1'b0);
   endtask

   task automatic drain_wait(input string tag);
      int n;
      n = 0;
      while (model_pending != 0 && n < 100) begin
         @(negedge clock);
         n++;
      end
      chk({tag, "_done_pulse"}, flush_done, 1);
      @(negedge clock);
      chk({tag, "_done_clear"}, flush_done, 0);
      chk({tag, "_idle_ready"}, m_ready_out, 0);
   endtask

   task automatic flush_empty(input string tag);
      flush = 1'b1;
      @(negedge clock);
      flush = 1'b0;
      drain_wait(tag);
   endtask

   initial begin
      int wbase;
      int stall_exp;
      int n;
      logic [31:0]  a0;
      logic [511:0] d0;
      logic [63:0]  b0;

      // Reset state
      repeat (2) @(negedge clock);
      chk("rst_ready", m_ready_out, 0);
      chk("rst_write", avm_write, 0);
      chk("rst_burst", avm_burstcount, 1);
      chk("rst_read", avm_read, 0);
      chk("rst_addr", avm_address, 0);
      chk("rst_be", avm_byteenable, 0);
      chk("rst_lines", lines_written, 0);
      chk("rst_pending", has_a_write_pending, 0);
      chk("rst_done", flush_done, 0);
      resetn = 1'b1;
      @(negedge clock);
      chk("idle_ready", m_ready_out, 0);

      // One full line, sequential data, slow acks
      ack_delay = 6;
      start(32'h1000);
      sent.delete();
      for (int i = 0; i < 32; i++) send(16'(i), 1'b0);
      chk("t1_write_latency", avm_write, 1);
      chk("t1_addr", avm_address, 32'h1000);
      chk("t1_be", avm_byteenable, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("t1_data", avm_writedata, exp_data());
      chk("t1_ready_in_write", m_ready_out, 0);
      @(negedge clock);
      chk("t1_lines", lines_written, 1);
      chk("t1_write_dropped", avm_write, 0);
      chk("t1_back_to_fill", m_ready_out, 1);
      chk("t1_pending", has_a_write_pending, 1);

      // Flush with nothing buffered while one write is outstanding
      flush = 1'b1;
      @(negedge clock);
      flush = 1'b0;
      chk("t5_no_write", avm_write, 0);
      chk("t5_drain_ready", m_ready_out, 0);
      chk("t5_done_early", flush_done, 0);
      drain_wait("t5");
      chk("t5_write_count", wr_addr.size(), 1);

      // Two lines, first write stalled by waitrequest; late m_start ignored
      ack_delay = 2;
      start(32'h1000);
      wbase = wr_addr.size();
      sent.delete();
      send_rand(31);
      avm_waitrequest = 1'b1;
      send_rand(1);
      a0 = avm_address;
      d0 = avm_writedata;
      b0 = avm_byteenable;
      chk("t2_addr0", a0, 32'h1000);
      chk("t2_data0", d0, exp_data());
      for (int k = 1; k < 4; k++) begin
         @(negedge clock);
         if (k == 3) avm_waitrequest = 1'b0;
         chk("t2_hold_write", avm_write, 1);
         chk("t2_hold_addr", avm_address, 32'h1000);
         chk("t2_hold_data", avm_writedata, d0);
         chk("t2_hold_be", avm_byteenable, b0);
         chk("t2_hold_ready", m_ready_out, 0);
      end
      @(negedge clock);
      chk("t2_lines1", lines_written, 1);
`ifdef HIFP_PACK_STATS_EN
      chk("t2_stat", stat_stall_cycles, 3);
`else
      chk("t2_stat_off", stat_stall_cycles, 0);
`endif
      sent.delete();
      base_addr = 32'h5000;
      m_start   = 1'b1;
      send_rand(1);
      m_start   = 1'b0;
      send_rand(31);
      chk("t2_addr1", avm_address, 32'h1040);
      chk("t2_data1", avm_writedata, exp_data());
      @(negedge clock);
      chk("t2_lines2", lines_written, 2);
      chk("t2_log0", wr_addr[wbase], 32'h1000);
      chk("t2_log1", wr_addr[wbase+1], 32'h1040);

      // Partial line: four results, then a fifth accepted with the flush
      sent.delete();
      send_rand(4);
      send(16'($urandom), 1'b1);
      chk("t3_write", avm_write, 1);
      chk("t3_addr", avm_address, 32'h1080);
      chk("t3_be", avm_byteenable, 64'h3FF);
      chk("t3_data", avm_writedata, exp_data());
      @(negedge clock);
      chk("t3_lines", lines_written, 3);
      chk("t3_drain_ready", m_ready_out, 0);
      drain_wait("t3");

      // Throttle at MAX_PENDING=2 with address wrap-around
      ack_auto    = 1'b0;
      man_release = man_given;
      start(32'hFFFF_FFE5);
      sent.delete();
      send_rand(32);
      chk("t4_addr0", avm_address, 32'hFFFF_FFC0);
      @(negedge clock);
      sent.delete();
      send_rand(32);
      chk("t4_addr1_wrap", avm_address, 32'h0);
      @(negedge clock);
      sent.delete();
      send_rand(32);
      chk("t4_pending_flag", has_a_write_pending, 1);
      stall_exp = 0;
      n = 0;
      while (model_pending >= MAXP && n < 40) begin
         chk("t4_withheld", avm_write, 0);
         stall_exp++;
         if (n == 3) man_release = man_given + 1;
         @(negedge clock);
         n++;
      end
      chk("t4_released", avm_write, 1);
      chk("t4_addr2", avm_address, 32'h40);
      chk("t4_data2", avm_writedata, exp_data());
      @(negedge clock);
      chk("t4_lines", lines_written, 3);
`ifdef HIFP_PACK_STATS_EN
      chk("t4_stat", stat_stall_cycles, stall_exp);
`else
      chk("t4_stat_off", stat_stall_cycles, 0);
`endif
      ack_auto = 1'b1;
      flush_empty("t4");

      // Reset asserted while a line waits with two writes outstanding
      ack_auto    = 1'b0;
      man_release = man_given;
      start(32'h3000);
      sent.delete();
      send_rand(96);
      chk("t6_pre_pending", has_a_write_pending, 1);
      chk("t6_pre_throttle", avm_write, 0);
      #2 resetn = 1'b0;
      #1;
      chk("t6_rst_write", avm_write, 0);
      chk("t6_rst_addr", avm_address, 0);
      chk("t6_rst_data", avm_writedata, 0);
      chk("t6_rst_be", avm_byteenable, 0);
      chk("t6_rst_lines", lines_written, 0);
      chk("t6_rst_pending", has_a_write_pending, 0);
      chk("t6_rst_ready", m_ready_out, 0);
      chk("t6_rst_burst", avm_burstcount, 1);
      repeat (2) @(negedge clock);
      resetn   = 1'b1;
      ack_auto = 1'b1;
      @(negedge clock);
      chk("t6_idle_ready", m_ready_out, 0);
      start(32'h2000);
      sent.delete();
      send_rand(32);
      chk("t6_addr", avm_address, 32'h2000);
      chk("t6_be", avm_byteenable, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("t6_data", avm_writedata, exp_data());
      @(negedge clock);
      chk("t6_lines", lines_written, 1);
      flush_empty("t6");

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
